axi4_lite_arbiter: RTL and testbench

Shares one AXI4-Lite master port between two internal requesters, one transaction at a time. Each requester has a simple valid/ready command port and gets a done pulse carrying the response. The block sits between control-plane logic, such as register sequencers and status pollers, and a single AXI4-Lite master port that would otherwise need a separate interconnect slot or a plug. Arbitration is round-robin, and at most one transaction is outstanding.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/axi4_lite_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
// The state encoding and the AXI response codes are kept here for the top and the bench.
package axi_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester not granted last wins.
// The grant is one-hot, or zero when disabled or when nobody is requesting.
module rr_arbiter2
  import axi_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      if (&req_valid) grant = last_grant ? 2'b01 : 2'b10;
      else            grant = req_valid;
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite master port between two command requesters, one transaction
// at a time, with round-robin arbitration and a per-requester done pulse.
module axi4_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*DW-1:0]   req_wdata,
  input  logic [NUM_REQ*DW/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]      rsp_done,
  output logic [1:0]              rsp_resp,
  output logic [DW-1:0]           rsp_rdata,
  output logic [AW-1:0]           M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DW-1:0]           M_AXI_WDATA,
  output logic [DW/8-1:0]         M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [AW-1:0]           M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DW-1:0]           M_AXI_RDATA,
  input  logic                    M_AXI_RVALID,
  input  logic [1:0]              M_AXI_RRESP,
  output logic                    M_AXI_RREADY
);

  localparam int SW = DW / 8;

  arb_state_e           state;
  logic                 last_grant;
  logic                 owner;
  logic [AW-1:0]        cmd_addr;
  logic [DW-1:0]        cmd_wdata;
  logic [SW-1:0]        cmd_wstrb;
  logic [NUM_REQ-1:0]   grant;
  logic                 win;
  logic                 win_write;
  logic [AW-1:0]        win_addr;
  logic [DW-1:0]        win_wdata;
  logic [SW-1:0]        win_wstrb;
  logic                 aw_ok;
  logic                 w_ok;

  // Gating with reset keeps req_ready low while the block is being reset.
  rr_arbiter2 u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .enable     ((state == IDLE) && !reset),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign win       = grant[1];
  assign win_write = win ? req_write[1]        : req_write[0];
  assign win_addr  = win ? req_addr[AW +: AW]  : req_addr[0 +: AW];
  assign win_wdata = win ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
  assign win_wstrb = win ? req_wstrb[SW +: SW] : req_wstrb[0 +: SW];

  // A write channel counts as finished once its VALID is gone or is handshaking now.
  assign aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
  assign w_ok  = !M_AXI_WVALID  || M_AXI_WREADY;

  assign M_AXI_AWADDR = cmd_addr;
  assign M_AXI_ARADDR = cmd_addr;
  assign M_AXI_WDATA  = cmd_wdata;
  assign M_AXI_WSTRB  = cmd_wstrb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      cmd_addr      <= '0;
      cmd_wdata     <= '0;
      cmd_wstrb     <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_done      <= '0;
      rsp_resp      <= '0;
      rsp_rdata     <= '0;
    end else begin
      rsp_done <= '0;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner      <= win;
            last_grant <= win;
            cmd_addr   <= win_addr;
            cmd_wdata  <= win_wdata;
            cmd_wstrb  <= win_wstrb;
            if (win_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_ADDR_DATA;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if (aw_ok && w_ok) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_done     <= owner ? 2'b10 : 2'b01;
            state        <= IDLE;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_done     <= owner ? 2'b10 : 2'b01;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter: a latency-programmable slave model, a queue of
// expected transactions, and a monitor that checks each AXI beat and each rsp_done.
module tb_axi4_lite_arbiter;
  import axi_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, req_write, rsp_done, rsp_resp;
  logic [63:0]   req_addr, req_wdata;
  logic [7:0]    req_wstrb;
  logic [31:0]   rsp_rdata;
  logic [31:0]   M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic          M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic          M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]    M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0]   M_AXI_RDATA = '0;

  typedef struct {
    logic [1:0]  owner;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0;
  int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0;
  logic [1:0] b_resp_cfg = AXI_RESP_OKAY;
  logic [1:0] r_resp_cfg = AXI_RESP_OKAY;

  axi4_lite_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_done(rsp_done), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slaveData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    req_valid[r]          = 1'b1;
    req_write[r]          = wr;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    req_wstrb[r*4 +: 4]   = s;
  endtask

  function automatic void pushExpected(input logic [1:0] own, input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] s,
                                       input logic [1:0] resp, input logic [31:0] rd);
    exp_t e;
    e.owner = own; e.write = wr; e.addr = a; e.wdata = d; e.wstrb = s; e.resp = resp; e.rdata = rd;
    exp_q.push_back(e);
  endfunction

  task automatic waitIdle(input int maxc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("idle_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Slave model and monitor share one process so the beat checks see the READY just chosen.
  always @(negedge clk) begin : slave_mon
    exp_t e;
    if (M_AXI_AWVALID) begin
      M_AXI_AWREADY = (aw_cnt >= aw_lat);
      aw_cnt++;
      if (M_AXI_AWREADY) begin
        if (exp_q.size() == 0) checkOutput("aw_unexpected", 1, 0);
        else                   checkOutput("awaddr", M_AXI_AWADDR, exp_q[0].addr);
      end
    end else begin
      M_AXI_AWREADY = 1'b0;
      aw_cnt = 0;
    end
    if (M_AXI_WVALID) begin
      M_AXI_WREADY = (w_cnt >= w_lat);
      w_cnt++;
      if (M_AXI_WREADY) begin
        if (exp_q.size() == 0) checkOutput("w_unexpected", 1, 0);
        else begin
          checkOutput("wdata", M_AXI_WDATA, exp_q[0].wdata);
          checkOutput("wstrb", M_AXI_WSTRB, exp_q[0].wstrb);
        end
      end
    end else begin
      M_AXI_WREADY = 1'b0;
      w_cnt = 0;
    end
    if (M_AXI_ARVALID) begin
      M_AXI_ARREADY = (ar_cnt >= ar_lat);
      ar_cnt++;
      if (M_AXI_ARREADY) begin
        if (exp_q.size() == 0) checkOutput("ar_unexpected", 1, 0);
        else                   checkOutput("araddr", M_AXI_ARADDR, exp_q[0].addr);
      end
    end else begin
      M_AXI_ARREADY = 1'b0;
      ar_cnt = 0;
    end
    if (M_AXI_BREADY) begin
      M_AXI_BVALID = (b_cnt >= b_lat);
      b_cnt++;
    end else begin
      M_AXI_BVALID = 1'b0;
      b_cnt = 0;
    end
    M_AXI_BRESP  = M_AXI_BVALID ? b_resp_cfg : AXI_RESP_OKAY;
    M_AXI_RVALID = M_AXI_RREADY;
    M_AXI_RDATA  = M_AXI_RREADY ? slaveData(M_AXI_ARADDR) : 32'h0;
    M_AXI_RRESP  = M_AXI_RREADY ? r_resp_cfg : AXI_RESP_OKAY;
    if (rsp_done != 2'b00) begin
      if (exp_q.size() == 0) checkOutput("done_unexpected", rsp_done, 0);
      else begin
        e = exp_q.pop_front();
        checkOutput("done_owner", rsp_done, e.owner);
        checkOutput("done_resp", rsp_resp, e.resp);
        if (!e.write) checkOutput("done_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, cyc, last;
    reset = 1'b1; req_valid = 2'b11; req_write = '0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_done", rsp_done, 0);
    checkOutput("rst_rsp_resp", rsp_resp, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
    checkOutput("rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 0);
    checkOutput("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
    checkOutput("rst_araddr_wstrb", {M_AXI_ARADDR, M_AXI_WSTRB}, 0);
    req_valid = 2'b00;
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single write from requester 0");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    pushExpected(2'b01, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, AXI_RESP_OKAY, 0);
    #1 checkOutput("t1_req_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;
    checkOutput("t1_aw_w_valid_n1", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    @(negedge clk);
    checkOutput("t1_bready_n2", M_AXI_BREADY, 1);
    checkOutput("t1_aw_w_valid_n2", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b00);
    @(negedge clk);
    checkOutput("t1_done_n3", rsp_done, 2'b01);
    checkOutput("t1_resp_n3", rsp_resp, AXI_RESP_OKAY);
    waitIdle(50);

    $display("[TB] read from requester 1 returning SLVERR");
    r_resp_cfg = AXI_RESP_SLVERR;
    applyStimulus(1, 1'b0, 32'h40, 0, 0);
    pushExpected(2'b10, 1'b0, 32'h40, 0, 0, AXI_RESP_SLVERR, slaveData(32'h40));
    #1 checkOutput("t4_req_ready", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b00;
    checkOutput("t4_arvalid", {M_AXI_ARVALID, M_AXI_AWVALID}, 2'b10);
    @(negedge clk);
    checkOutput("t4_rready", M_AXI_RREADY, 1);
    @(negedge clk);
    checkOutput("t4_done", rsp_done, 2'b10);
    checkOutput("t4_resp", rsp_resp, AXI_RESP_SLVERR);
    waitIdle(50);
    r_resp_cfg = AXI_RESP_OKAY;

    $display("[TB] both requesters hold reads, grants alternate");
    applyStimulus(0, 1'b0, 32'h100, 0, 0);
    applyStimulus(1, 1'b0, 32'h204, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) pushExpected(2'b01, 1'b0, 32'h100, 0, 0, AXI_RESP_OKAY, slaveData(32'h100));
      else            pushExpected(2'b10, 1'b0, 32'h204, 0, 0, AXI_RESP_OKAY, slaveData(32'h204));
    end
    k = 0; cyc = 0; last = 0;
    #1;
    while (k < 4 && cyc < 60) begin
      if (req_ready != 2'b00) begin
        checkOutput("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        if (k > 0) checkOutput("t2_accept_period", 64'(cyc - last), 3);
        last = cyc;
        k++;
      end
      @(negedge clk); #1;
      cyc++;
    end
    req_valid = 2'b00;
    if (k < 4) checkOutput("t2_accept_timeout", 64'(k), 4);
    waitIdle(50);

    $display("[TB] W before AW, then AW before W");
    for (int pass = 0; pass < 2; pass++) begin
      aw_lat = (pass == 0) ? 3 : 0;
      w_lat  = (pass == 0) ? 0 : 3;
      applyStimulus(0, 1'b1, 32'h1000 + 32'(pass), 32'hA5A5_0000 + 32'(pass), 4'h3);
      pushExpected(2'b01, 1'b1, 32'h1000 + 32'(pass), 32'hA5A5_0000 + 32'(pass), 4'h3, AXI_RESP_OKAY, 0);
      #1 checkOutput("t3_req_ready", req_ready, 2'b01);
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) req_valid = 2'b00;
        checkOutput("t3_awvalid", M_AXI_AWVALID, 64'(c <= aw_lat + 1));
        checkOutput("t3_wvalid", M_AXI_WVALID, 64'(c <= w_lat + 1));
        checkOutput("t3_bready", M_AXI_BREADY, 64'(c == 5));
      end
      @(negedge clk);
      checkOutput("t3_done", rsp_done, 2'b01);
      waitIdle(50);
    end
    aw_lat = 0; w_lat = 0;

    $display("[TB] ARREADY held low for 20 cycles");
    ar_lat = 20;
    applyStimulus(0, 1'b0, 32'h3C, 0, 0);
    pushExpected(2'b01, 1'b0, 32'h3C, 0, 0, AXI_RESP_OKAY, slaveData(32'h3C));
    pushExpected(2'b10, 1'b0, 32'h80, 0, 0, AXI_RESP_OKAY, slaveData(32'h80));
    #1 checkOutput("t5_req_ready", req_ready, 2'b01);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid[0] = 1'b0;
        applyStimulus(1, 1'b0, 32'h80, 0, 0);
      end
      #1;
      checkOutput("t5_arvalid", M_AXI_ARVALID, 1);
      checkOutput("t5_araddr", M_AXI_ARADDR, 32'h3C);
      checkOutput("t5_req_ready", req_ready, 2'b00);
    end
    ar_lat = 0;
    cyc = 0;
    while (req_ready != 2'b10 && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    checkOutput("t5_req1_grant", req_ready, 2'b10);
    @(negedge clk); req_valid = 2'b00;
    waitIdle(50);

    $display("[TB] reset while waiting for the write response");
    b_lat = 10;
    applyStimulus(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    pushExpected(2'b01, 1'b1, 32'h20, 32'h1234_5678, 4'hF, AXI_RESP_OKAY, 0);
    #1 checkOutput("t6_req_ready", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;
    cyc = 0;
    while (!M_AXI_BREADY && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t6_bready_before_reset", M_AXI_BREADY, 1);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    b_lat = 0;
    checkOutput("t6_bready_after_reset", M_AXI_BREADY, 0);
    checkOutput("t6_done_after_reset", rsp_done, 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_no_done", rsp_done, 0);
    end
    applyStimulus(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'h5);
    applyStimulus(1, 1'b0, 32'h34, 0, 0);
    pushExpected(2'b01, 1'b1, 32'h30, 32'hCAFE_F00D, 4'h5, AXI_RESP_OKAY, 0);
    #1 checkOutput("t6_tie_after_reset", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b00;
    waitIdle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
